// File: rtl/uart_bus_arb_if.sv
// rtl/uart_bus_arb_if.sv - bus bundle between two requesters, the arbiter and the UART MMIO port
//
// Signals:
//   m0_*/m1_*  : per-master request side (req, lock, we, addr, wdata in; rdata, ack out)
//   addr, write_data, write_enable, read_enable : shared port toward the UART MMIO block
//   read_data  : UART MMIO read data, valid the cycle after read_enable
//   grant      : one-hot current owner, 00 when idle
// Modports:
//   slave  : arbiter view
//   master : environment view (both requesters plus the UART MMIO block)
interface uart_bus_arb_if;
    logic        m0_req;
    logic        m1_req;
    logic        m0_lock;
    logic        m1_lock;
    logic        m0_we;
    logic        m1_we;
    logic [31:0] m0_addr;
    logic [31:0] m1_addr;
    logic [7:0]  m0_wdata;
    logic [7:0]  m1_wdata;
    logic [7:0]  m0_rdata;
    logic [7:0]  m1_rdata;
    logic        m0_ack;
    logic        m1_ack;
    logic [31:0] addr;
    logic [7:0]  write_data;
    logic        write_enable;
    logic        read_enable;
    logic [7:0]  read_data;
    logic [1:0]  grant;

    modport slave (
        input  m0_req, m1_req, m0_lock, m1_lock, m0_we, m1_we,
        input  m0_addr, m1_addr, m0_wdata, m1_wdata, read_data,
        output m0_rdata, m1_rdata, m0_ack, m1_ack,
        output addr, write_data, write_enable, read_enable, grant
    );

    modport master (
        output m0_req, m1_req, m0_lock, m1_lock, m0_we, m1_we,
        output m0_addr, m1_addr, m0_wdata, m1_wdata, read_data,
        input  m0_rdata, m1_rdata, m0_ack, m1_ack,
        input  addr, write_data, write_enable, read_enable, grant
    );
endinterface

// File: rtl/uart_bus_arb.sv
// rtl/uart_bus_arb.sv - two-master arbiter for the UART MMIO register port
//
// Purpose: serialises master 0 / master 1 accesses onto the single UART MMIO
// port. Each access is IDLE (arbitrate, latch) -> ISSUE (one strobe) ->
// RESP (ack, read data capture). Round-robin with optional lock bursts of up
// to MAX_BURST locked re-grants.
// Build option: define UART_ARB_PRIORITY_EN for fixed priority (master 0 wins ties).
//
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : uart_bus_arb_if.slave (master requests, UART MMIO port, grant)
// Parameters:
//   MAX_BURST : maximum consecutive locked re-grants before forced rotation (1..15)
module uart_bus_arb #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           reset,
    uart_bus_arb_if.slave  bus
);

    localparam logic [3:0] C_MAX = 4'(MAX_BURST);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_owner;     // 0 = master 0, 1 = master 1
    logic        r_last;      // owner of the most recent grant
    logic        r_we;
    logic        r_lock;      // lock flag of the latched access
    logic [3:0]  r_burst;
    logic [31:0] r_addr;
    logic [7:0]  r_wdata;
    logic        r_we_o;
    logic        r_re_o;
    logic        r_ack0;
    logic        r_ack1;
    logic [7:0]  r_rdata0;
    logic [7:0]  r_rdata1;
    logic [1:0]  r_grant;

    logic        w_any;
    logic        w_win;
    logic        w_regrant;
    logic [3:0]  w_burst_nxt;
    logic        w_we;
    logic        w_lock;
    logic [31:0] w_addr;
    logic [7:0]  w_wdata;

    assign w_any = bus.m0_req | bus.m1_req;

    always_comb begin
        w_win = 1'b0;
        if (bus.m0_req && !bus.m1_req) begin
            w_win = 1'b0;
        end else if (bus.m1_req && !bus.m0_req) begin
            w_win = 1'b1;
        end else begin
`ifdef UART_ARB_PRIORITY_EN
            w_win = 1'b0;
`else
            // Tie: the previous owner keeps the port only while its lock
            // burst has budget left; otherwise the pointer rotates.
            w_win = (r_lock && (r_burst < C_MAX)) ? r_last : ~r_last;
`endif
        end
    end

    // A locked re-grant is the previous owner winning again after an access
    // that asked to keep the port. Saturates when the other master is idle.
    assign w_regrant   = r_lock && (w_win == r_last);
    assign w_burst_nxt = !w_regrant ? 4'd0 :
                         (r_burst >= C_MAX) ? C_MAX : r_burst + 4'd1;

    assign w_we    = w_win ? bus.m1_we    : bus.m0_we;
    assign w_lock  = w_win ? bus.m1_lock  : bus.m0_lock;
    assign w_addr  = w_win ? bus.m1_addr  : bus.m0_addr;
    assign w_wdata = w_win ? bus.m1_wdata : bus.m0_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_owner  <= 1'b0;
            r_last   <= 1'b1;
            r_we     <= 1'b0;
            r_lock   <= 1'b0;
            r_burst  <= 4'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 8'd0;
            r_we_o   <= 1'b0;
            r_re_o   <= 1'b0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_rdata0 <= 8'd0;
            r_rdata1 <= 8'd0;
            r_grant  <= 2'b00;
        end else begin
            r_we_o <= 1'b0;
            r_re_o <= 1'b0;
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner <= w_win;
                        r_last  <= w_win;
                        r_we    <= w_we;
                        r_lock  <= w_lock;
                        r_burst <= w_burst_nxt;
                        r_addr  <= w_addr;
                        r_wdata <= w_wdata;
                        r_we_o  <= w_we;
                        r_re_o  <= ~w_we;
                        r_grant <= w_win ? 2'b10 : 2'b01;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_ack0  <= ~r_owner;
                    r_ack1  <= r_owner;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (!r_we) begin
                        if (r_owner) begin
                            r_rdata1 <= bus.read_data;
                        end else begin
                            r_rdata0 <= bus.read_data;
                        end
                    end
                    r_grant <= 2'b00;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.addr         = r_addr;
    assign bus.write_data   = r_wdata;
    assign bus.write_enable = r_we_o;
    assign bus.read_enable  = r_re_o;
    assign bus.m0_ack       = r_ack0;
    assign bus.m1_ack       = r_ack1;
    assign bus.grant        = r_grant;

    // The slave's read data only arrives in the ack cycle, so it is passed
    // straight through then and held from the capture register afterwards.
    assign bus.m0_rdata = (r_state == S_RESP && !r_owner && !r_we) ? bus.read_data : r_rdata0;
    assign bus.m1_rdata = (r_state == S_RESP &&  r_owner && !r_we) ? bus.read_data : r_rdata1;

endmodule

// File: tb/tb_uart_bus_arb.sv
// tb/tb_uart_bus_arb.sv - self-checking bench for uart_bus_arb
module tb_uart_bus_arb;

    localparam int MAXB = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_bus_arb_if bus();

    uart_bus_arb #(.MAX_BURST(MAXB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] mem [16];

    always @(posedge clk) bus.read_data <= mem[bus.addr[3:0]];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int served[$];
    int ack_cyc[$];

    // transaction-level reference: phase 0 = free, 1 = strobe cycle, 2 = ack cycle
    int          m_ph;
    bit          m_w;
    bit          m_we;
    bit          m_lk;
    bit          m_last;
    int          m_cnt;
    logic [31:0] m_addr;
    logic [7:0]  m_wd;
    logic [7:0]  m_rd [2];
    bit          e_ack0;
    bit          e_ack1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_w = 0; m_we = 0; m_lk = 0; m_last = 1; m_cnt = 0;
        m_addr = 0; m_wd = 0; m_rd[0] = 0; m_rd[1] = 0;
    endtask

    task automatic model_advance();
        bit r0, r1, w;
        r0 = bus.m0_req;
        r1 = bus.m1_req;
        if (reset) begin
            model_reset();
        end else if (m_ph == 0) begin
            if (r0 || r1) begin
                if (r0 && r1) begin
`ifdef UART_ARB_PRIORITY_EN
                    w = 0;
`else
                    w = (m_lk && m_cnt < MAXB) ? m_last : !m_last;
`endif
                end else begin
                    w = r1;
                end
                if (m_lk && w == m_last) m_cnt = (m_cnt >= MAXB) ? MAXB : m_cnt + 1;
                else m_cnt = 0;
                m_w = w; m_last = w;
                m_we   = w ? bus.m1_we    : bus.m0_we;
                m_lk   = w ? bus.m1_lock  : bus.m0_lock;
                m_addr = w ? bus.m1_addr  : bus.m0_addr;
                m_wd   = w ? bus.m1_wdata : bus.m0_wdata;
                m_ph = 1;
            end
        end else if (m_ph == 1) begin
            m_ph = 2;
        end else begin
            if (!m_we) m_rd[m_w] = mem[m_addr[3:0]];
            m_ph = 0;
        end
    endtask

    task automatic check_out();
        logic [1:0] eg;
        logic [7:0] er0, er1;
        eg = (m_ph == 0) ? 2'b00 : (m_w ? 2'b10 : 2'b01);
        e_ack0 = (m_ph == 2) && !m_w;
        e_ack1 = (m_ph == 2) &&  m_w;
        er0 = (e_ack0 && !m_we) ? mem[m_addr[3:0]] : m_rd[0];
        er1 = (e_ack1 && !m_we) ? mem[m_addr[3:0]] : m_rd[1];
        chk("grant",        bus.grant,        eg);
        chk("write_enable", bus.write_enable, (m_ph == 1) &&  m_we);
        chk("read_enable",  bus.read_enable,  (m_ph == 1) && !m_we);
        chk("addr",         bus.addr,         m_addr);
        chk("write_data",   bus.write_data,   m_wd);
        chk("m0_ack",       bus.m0_ack,       e_ack0);
        chk("m1_ack",       bus.m1_ack,       e_ack1);
        chk("m0_rdata",     bus.m0_rdata,     er0);
        chk("m1_rdata",     bus.m1_rdata,     er1);
        if (e_ack0) begin served.push_back(0); ack_cyc.push_back(cyc); end
        if (e_ack1) begin served.push_back(1); ack_cyc.push_back(cyc); end
    endtask

    task automatic tick();
        model_advance();
        @(posedge clk);
        #1;
        cyc++;
        check_out();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        served.delete();
        ack_cyc.delete();
    endtask

    task automatic set_m(input int i, input bit rq, input bit we, input bit lk,
                         input logic [31:0] a, input logic [7:0] d);
        if (i == 0) begin
            bus.m0_req = rq; bus.m0_we = we; bus.m0_lock = lk; bus.m0_addr = a; bus.m0_wdata = d;
        end else begin
            bus.m1_req = rq; bus.m1_we = we; bus.m1_lock = lk; bus.m1_addr = a; bus.m1_wdata = d;
        end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) mem[k] = 8'($urandom);
        mem[0] = 8'h5A;
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0);
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_out();
        reset = 1'b0;

        // m0 write 0x41 to 0x04
        set_m(0, 1, 1, 0, 32'h4, 8'h41);
        tick();
        chk("A_we",    bus.write_enable, 1);
        chk("A_addr",  bus.addr,         32'h4);
        chk("A_wdata", bus.write_data,   8'h41);
        chk("A_grant", bus.grant,        2'b01);
        tick();
        chk("A_ack",   bus.m0_ack,       1);
        chk("A_grant2", bus.grant,       2'b01);
        bus.m0_req = 0;
        tick();
        chk("A_ack_low", bus.m0_ack,     0);
        chk("A_idle_grant", bus.grant,   2'b00);

        // m1 read from 0x00, slave returns 0x5A
        set_m(1, 1, 0, 0, 32'h0, 8'h00);
        tick();
        chk("B_re",    bus.read_enable,  1);
        chk("B_grant", bus.grant,        2'b10);
        tick();
        chk("B_ack",   bus.m1_ack,       1);
        chk("B_rdata", bus.m1_rdata,     8'h5A);
        bus.m1_req = 0;
        tick();
        tick();
        chk("B_rdata_held", bus.m1_rdata, 8'h5A);

`ifndef UART_ARB_PRIORITY_EN
        // both requesting without lock: m0, m1, m0, m1 every 3 cycles
        do_reset();
        set_m(0, 1, 1, 0, 32'h1, 8'h11);
        set_m(1, 1, 0, 0, 32'h2, 8'h22);
        for (int k = 0; k < 40 && served.size() < 4; k++) tick();
        chk("C_count", served.size(), 4);
        for (int k = 0; k < 4 && k < served.size(); k++) chk("C_order", served[k], k % 2);
        for (int k = 1; k < 4 && k < ack_cyc.size(); k++) chk("C_spacing", ack_cyc[k] - ack_cyc[k-1], 3);
        bus.m0_req = 0; bus.m1_req = 0;
        tick();

        // m1 locked burst against a continuously requesting m0
        do_reset();
        set_m(1, 1, 0, 1, 32'h3, 8'h00);
        tick();
        set_m(0, 1, 1, 0, 32'h5, 8'h55);
        for (int k = 0; k < 60 && served.size() < 6; k++) tick();
        chk("D_count", served.size(), 6);
        for (int k = 0; k < 6 && k < served.size(); k++) chk("D_order", served[k], (k < 5) ? 1 : 0);
        bus.m0_req = 0; bus.m1_req = 0; bus.m1_lock = 0;
        tick();
`else
        // fixed priority: m1 starves while m0 requests
        do_reset();
        set_m(0, 1, 1, 0, 32'h1, 8'h11);
        set_m(1, 1, 0, 1, 32'h2, 8'h22);
        for (int k = 0; k < 60 && served.size() < 6; k++) tick();
        chk("F_count", served.size(), 6);
        for (int k = 0; k < 6 && k < served.size(); k++) chk("F_order", served[k], 0);
        bus.m0_req = 0;
        for (int k = 0; k < 10 && served.size() < 7; k++) tick();
        chk("F_m1_after", (served.size() >= 7) ? served[6] : -1, 1);
        bus.m1_req = 0;
        tick();
`endif

        // reset during the ISSUE cycle of an m0 write
        do_reset();
        set_m(0, 1, 1, 0, 32'h8, 8'h77);
        tick();
        chk("E_we", bus.write_enable, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("E_ack",   bus.m0_ack,       0);
        chk("E_grant", bus.grant,        2'b00);
        chk("E_addr",  bus.addr,         32'h0);
        chk("E_wdata", bus.write_data,   8'h00);
        chk("E_we0",   bus.write_enable, 0);
        for (int k = 0; k < 10 && served.size() < 1; k++) tick();
        chk("E_resume", (served.size() >= 1) ? served[0] : -1, 0);
        bus.m0_req = 0;
        tick();

        // random traffic against the reference
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            tick();
            if (e_ack0 || !bus.m0_req)
                set_m(0, $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), $urandom, 8'($urandom));
            if (e_ack1 || !bus.m1_req)
                set_m(1, $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), $urandom, 8'($urandom));
        end
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (e_ack0) bus.m0_req = 0;
            if (e_ack1) bus.m1_req = 0;
        end
        bus.m0_req = 0; bus.m1_req = 0;
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_bus_arb.md
# uart_bus_arb

Two-master arbiter that shares the single register port of the UART MMIO block between the CPU load/store path (master 0) and a secondary requester such as a boot loader or debug engine (master 1). It serialises accesses, routes each master's address, write data and strobes onto the shared port, and returns read data with a one-cycle acknowledge. Fairness is round-robin, with an optional lock for short bursts. It sits between the masters and the UART MMIO block in the peripheral bus path.

## Interface
- MAX_BURST, 4: maximum consecutive locked accesses before forced rotation (1..15).
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- m0_req, m1_req  in  1  access request; held with address/data stable until the matching ack.
- m0_lock, m1_lock  in  1  sampled with req; asks to keep the grant for the next access.
- m0_we, m1_we  in  1  1 = write, 0 = read.
- m0_addr, m1_addr  in  32  byte address.
- m0_wdata, m1_wdata  in  8  write data.
- m0_rdata, m1_rdata  out  8  read data, valid in the ack cycle, held until the next ack to that master.
- m0_ack, m1_ack  out  1  one-cycle completion pulse.
- addr  out  32  to the UART MMIO block.
- write_data  out  8  to the UART MMIO block.
- write_enable, read_enable  out  1  one-cycle strobes to the UART MMIO block.
- read_data  in  8  from the UART MMIO block, valid the cycle after read_enable.
- grant  out  2  one-hot current owner (debug/status); 00 when idle.

## Operation
- FSM with three states: IDLE, ISSUE, RESP.
- IDLE: if any req is asserted, pick a winner, latch its addr, we and wdata, set grant, and go to ISSUE.
- ISSUE: assert exactly one of write_enable or read_enable for one cycle with the latched addr and write_data, then go to RESP.
- RESP: for a read, capture read_data into the winner's rdata register. Pulse the winner's ack. Go to IDLE.
- Winner selection:
  - Only one req asserted: that master wins.
  - Both asserted: the master not granted last wins (round-robin pointer `last`).
  - Lock: if the previous owner's access completed with lock=1, it is re-requesting, and burst_cnt < MAX_BURST, it keeps the grant even if the other master requests.
- burst_cnt (4 bits):
  - Increments on each locked re-grant.
  - Clears on any change of owner or any access with lock=0.
  - When burst_cnt reaches MAX_BURST and the other master is requesting, the grant rotates.
  - If the other master is idle, the owner continues and burst_cnt saturates at MAX_BURST.
- Downstream outputs during IDLE/RESP: addr and write_data hold their last latched values; strobes are 0.
- A master that keeps req high in the cycle after its ack is treated as making a new request. It competes normally in that IDLE cycle.
- A req withdrawn before ack is a protocol violation. The arbiter still completes the latched access and pulses ack.

## Timing
- Reset values: state IDLE, grant 00, addr 0, write_data 0, both strobes 0, both acks 0, both rdata 0x00, last = master 1 (so master 0 wins the first tie), burst_cnt 0.
- Read or write latency, req seen in IDLE at cycle N:
  - N+1: strobe asserted (ISSUE).
  - N+2: ack pulse (RESP).
  - N+3: earliest next IDLE sample.
- Peak throughput is one access per 3 cycles.
- reset asserted in any state: the next cycle is IDLE with reset values. An in-flight strobe or ack is dropped and never re-issued.
- Exactly one strobe is high per access, and never both. At most one ack is high in any cycle.

## Configuration
- UART_ARB_PRIORITY_EN defined: fixed priority, master 0 always wins a tie. Lock and MAX_BURST still apply to master 1 bursts, but a master 0 request during a master 1 burst wins at the next IDLE regardless of burst_cnt.
- UART_ARB_PRIORITY_EN undefined: round-robin as described in Operation.

## Test plan
- Reset, then m0 writes addr 0x04, data 0x41 -> write_enable=1 with addr 0x04 and write_data 0x41 at N+1; m0_ack at N+2; grant=01 during the access.
- m1 reads 0x00 while the slave returns 0x5A -> read_enable at N+1; m1_rdata=0x5A and m1_ack at N+2; m1_rdata still 0x5A afterwards.
- Both masters request continuously without lock, first tie right after reset -> grant order m0, m1, m0, m1; acks alternate every 3 cycles.
- m1 requests with lock=1 continuously, m0 requesting throughout, MAX_BURST=4 -> m1 is served 5 times (1 + 4 locked re-grants), then m0 is granted.
- reset asserted in the ISSUE cycle of an m0 write -> no ack for that write; the next cycle shows IDLE with all outputs at reset values; a subsequent request completes normally.
- With UART_ARB_PRIORITY_EN defined, both masters requesting continuously -> m0 is granted every access and m1 is never acked until m0 drops req.
